vedic_mul_pipe: RTL and testbench

- Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier for the 32-bit datapath.
- Next generation of the team's combinational 8x8 quadrant-split multiplier.
- Adds a generic WIDTH, three register stages, valid/ready handshaking with backpressure, and per-transaction signed/unsigned mode.
- Sits between the operand-fetch stage and the accumulator.

---
 rtl/vedic_mul_pipe.sv | 122 ++++++++++++
 tb/tb_vedic_mul_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_pipe.sv
// rtl/vedic_mul_pipe.sv - three-stage quadrant-split multiplier with valid/ready flow control
module vedic_mul_pipe #(
    parameter int WIDTH = 32,
    localparam int HALF = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y,
    output logic                 out_signed
);

    logic adv;
    logic xfer;

    // One shared enable: bubbles travel with the data rather than being squeezed out.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign xfer     = in_valid && adv;

    // Stage 1: sign handling and magnitudes
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             neg1;
    logic             sg1;
    logic             v1;

    // The most negative operand negates to itself, which reads back correctly as an unsigned magnitude.
    assign mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1   <= '0;
            b1   <= '0;
            neg1 <= 1'b0;
            sg1  <= 1'b0;
            v1   <= 1'b0;
        end else if (adv) begin
            v1 <= xfer;
            if (xfer) begin
                a1   <= mag_a;
                b1   <= mag_b;
                neg1 <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                sg1  <= in_signed;
            end
        end
    end

    // Stage 2: vertical and crosswise quadrant products
    logic [WIDTH-1:0] al;
    logic [WIDTH-1:0] ah;
    logic [WIDTH-1:0] bl;
    logic [WIDTH-1:0] bh;
    logic [WIDTH-1:0] ll2;
    logic [WIDTH-1:0] hl2;
    logic [WIDTH-1:0] lh2;
    logic [WIDTH-1:0] hh2;
    logic             neg2;
    logic             sg2;
    logic             v2;

    assign al = {{HALF{1'b0}}, a1[HALF-1:0]};
    assign ah = {{HALF{1'b0}}, a1[WIDTH-1:HALF]};
    assign bl = {{HALF{1'b0}}, b1[HALF-1:0]};
    assign bh = {{HALF{1'b0}}, b1[WIDTH-1:HALF]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ll2  <= '0;
            hl2  <= '0;
            lh2  <= '0;
            hh2  <= '0;
            neg2 <= 1'b0;
            sg2  <= 1'b0;
            v2   <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                ll2  <= al * bl;
                hl2  <= ah * bl;
                lh2  <= al * bh;
                hh2  <= ah * bh;
                neg2 <= neg1;
                sg2  <= sg1;
            end
        end
    end

    // Stage 3: recombine and apply sign; the product of two magnitudes never carries past 2*WIDTH bits
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] y;

    assign p = {hh2, {WIDTH{1'b0}}}
             + ({{WIDTH{1'b0}}, hl2} << HALF)
             + ({{WIDTH{1'b0}}, lh2} << HALF)
             + {{WIDTH{1'b0}}, ll2};
    assign y = neg2 ? -p : p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_y      <= '0;
            out_signed <= 1'b0;
            out_valid  <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                out_y      <= y;
                out_signed <= sg2;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// tb/tb_vedic_mul_pipe.sv - randomized self-checking bench for vedic_mul_pipe
module tb_vedic_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // 32-bit device
    logic        m_iv, m_ir, m_s, m_ov, m_or, m_os;
    logic [31:0] m_a, m_b;
    logic [63:0] m_y;

    vedic_mul_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_iv), .in_ready(m_ir), .in_a(m_a), .in_b(m_b), .in_signed(m_s),
        .out_valid(m_ov), .out_ready(m_or), .out_y(m_y), .out_signed(m_os)
    );

    // Parameter sweep devices
    logic        sw_rdy;
    logic        v4, r4, s4, ov4, os4;
    logic [3:0]  a4, b4;
    logic [7:0]  y4;
    logic        v8u, r8u, ov8u, os8u;
    logic [7:0]  a8u, b8u;
    logic [15:0] y8u;
    logic        v8s, r8s, ov8s, os8s;
    logic [7:0]  a8s, b8s;
    logic [15:0] y8s;
    logic        v16, r16, s16, ov16, os16;
    logic [15:0] a16, b16;
    logic [31:0] y16;
    logic        s8u_c, s8s_c;

    vedic_mul_pipe #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4), .in_a(a4), .in_b(b4), .in_signed(s4),
        .out_valid(ov4), .out_ready(sw_rdy), .out_y(y4), .out_signed(os4)
    );
    vedic_mul_pipe #(.WIDTH(8)) u8u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8u), .in_ready(r8u), .in_a(a8u), .in_b(b8u), .in_signed(s8u_c),
        .out_valid(ov8u), .out_ready(sw_rdy), .out_y(y8u), .out_signed(os8u)
    );
    vedic_mul_pipe #(.WIDTH(8)) u8s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8s), .in_ready(r8s), .in_a(a8s), .in_b(b8s), .in_signed(s8s_c),
        .out_valid(ov8s), .out_ready(sw_rdy), .out_y(y8s), .out_signed(os8s)
    );
    vedic_mul_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16), .in_signed(s16),
        .out_valid(ov16), .out_ready(sw_rdy), .out_y(y16), .out_signed(os16)
    );

    // Reference: interpret operands as integers, multiply, keep the low 2*w bits
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] z,
                                            input logic s, input int w);
        logic [63:0] msk, sx, sz, p;
        msk = (64'd1 << w) - 64'd1;
        sx  = {32'd0, x} & msk;
        sz  = {32'd0, z} & msk;
        if (s && sx[w-1]) sx = sx - (64'd1 << w);
        if (s && sz[w-1]) sz = sz - (64'd1 << w);
        p = sx * sz;
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] z, input logic s,
                         output logic [2:0] vh, output logic [63:0] yy, output logic oss);
        @(negedge clk);
        m_a = x; m_b = z; m_s = s; m_iv = 1'b1; m_or = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        vh[0] = m_ov;
        @(negedge clk);
        vh[1] = m_ov;
        @(negedge clk);
        vh[2] = m_ov;
        yy    = m_y;
        oss   = m_os;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", m_ov); end
        n_checks++;
        if (m_y !== 64'd0) begin n_fail++; $display("FAIL reset_out_y: got %h expected 0", m_y); end
        n_checks++;
        if (m_os !== 1'b0) begin n_fail++; $display("FAIL reset_out_signed: got %b expected 0", m_os); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", m_ir); end
    endtask

    task automatic test_unsigned_max();
        logic [2:0] vh; logic [63:0] yy; logic oss;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, vh, yy, oss);
        n_checks++;
        if (vh !== 3'b100) begin n_fail++; $display("FAIL umax_latency: got %b expected 100", vh); end
        n_checks++;
        if (yy !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL umax_value: got %h expected fffffffe00000001", yy); end
        n_checks++;
        if (oss !== 1'b0) begin n_fail++; $display("FAIL umax_signed: got %b expected 0", oss); end
    endtask

    task automatic test_signed();
        logic [2:0] vh; logic [63:0] yy; logic oss;
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, vh, yy, oss);
        n_checks++;
        if (vh !== 3'b100 || yy !== 64'h4000_0000_0000_0000) begin
            n_fail++; $display("FAIL signed_minmin: got v=%b y=%h expected v=100 y=4000000000000000", vh, yy);
        end
        issue(32'hFFFF_FFF9, 32'd6, 1'b1, vh, yy, oss);
        n_checks++;
        if (yy !== 64'hFFFF_FFFF_FFFF_FFD6) begin n_fail++; $display("FAIL signed_m7x6: got %h expected ffffffffffffffd6", yy); end
        n_checks++;
        if (oss !== 1'b1) begin n_fail++; $display("FAIL signed_m7x6_flag: got %b expected 1", oss); end
        issue(32'd0, 32'h1234_5678, 1'b0, vh, yy, oss);
        n_checks++;
        if (yy !== 64'd0) begin n_fail++; $display("FAIL zero_unsigned: got %h expected 0", yy); end
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, vh, yy, oss);
        n_checks++;
        if (yy !== 64'd0) begin n_fail++; $display("FAIL zero_signed_neg: got %h expected 0", yy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_y[100];
        logic        exp_s[100];
        for (int i = 0; i < 104; i++) begin
            @(negedge clk);
            m_or = 1'b1;
            if (i < 100) begin
                m_a = $urandom; m_b = $urandom; m_s = 1'($urandom_range(0, 1)); m_iv = 1'b1;
                exp_y[i] = ref_mul(m_a, m_b, m_s, 32);
                exp_s[i] = m_s;
            end else begin
                m_iv = 1'b0;
            end
            #1;
            n_checks++;
            if (m_ov !== ((i >= 3) && (i < 103))) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, m_ov, (i >= 3) && (i < 103));
            end
            if (i >= 3 && i < 103) begin
                n_checks++;
                if (m_y !== exp_y[i-3] || m_os !== exp_s[i-3]) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h/%b expected %h/%b", i - 3, m_y, m_os, exp_y[i-3], exp_s[i-3]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [64:0] q[$];
        logic [64:0] e;
        int          accepted = 0;
        int          emitted  = 0;
        logic        held     = 1'b0;
        logic [63:0] held_y   = '0;
        logic        held_s   = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (held) begin
                n_checks++;
                if (m_ov !== 1'b1 || m_y !== held_y || m_os !== held_s) begin
                    n_fail++; $display("FAIL bp_stall_hold[%0d]: got v=%b y=%h expected v=1 y=%h", c, m_ov, m_y, held_y);
                end
            end
            m_or = ($urandom_range(0, 9) >= 3);
            m_iv = 1'($urandom_range(0, 1));
            m_a  = $urandom; m_b = $urandom; m_s = 1'($urandom_range(0, 1));
            #1;
            if (m_ov && !m_or) begin
                n_checks++;
                if (m_ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, m_ir); end
            end
            if (m_ov && m_or) begin
                emitted++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra_output[%0d]: got %h expected nothing", c, m_y);
                end else begin
                    e = q.pop_front();
                    if ({m_os, m_y} !== e) begin
                        n_fail++; $display("FAIL bp_data[%0d]: got %b/%h expected %b/%h", c, m_os, m_y, e[64], e[63:0]);
                    end
                end
            end
            if (m_iv && m_ir) begin
                accepted++;
                q.push_back({m_s, ref_mul(m_a, m_b, m_s, 32)});
            end
            held   = m_ov && !m_or;
            held_y = m_y;
            held_s = m_os;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            m_iv = 1'b0; m_or = 1'b1;
            #1;
            if (m_ov) begin
                emitted++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_drain_extra: got %h expected nothing", m_y);
                end else begin
                    e = q.pop_front();
                    if ({m_os, m_y} !== e) begin
                        n_fail++; $display("FAIL bp_drain_data: got %b/%h expected %b/%h", m_os, m_y, e[64], e[63:0]);
                    end
                end
            end
        end
        n_checks++;
        if (accepted !== emitted || q.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got emitted=%0d expected accepted=%0d", emitted, accepted);
        end
    endtask

    task automatic test_reset_midstream();
        logic [2:0] vh; logic [63:0] yy; logic oss;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_iv = 1'b1; m_or = 1'b1; m_s = 1'b0;
            m_a = $urandom; m_b = $urandom;
        end
        @(negedge clk);
        m_iv = 1'b0; m_or = 1'b0;
        n_checks++;
        if (m_ov !== 1'b1) begin n_fail++; $display("FAIL mid_full: got %b expected 1", m_ov); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear: got %b expected 0", m_ov); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; m_or = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_ov !== 1'b0) begin n_fail++; $display("FAIL mid_ghost[%0d]: got %b expected 0", i, m_ov); end
        end
        issue(32'd3, 32'd5, 1'b0, vh, yy, oss);
        n_checks++;
        if (vh !== 3'b100 || yy !== 64'd15) begin
            n_fail++; $display("FAIL mid_after: got v=%b y=%h expected v=100 y=f", vh, yy);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] a16s[2000];
        logic [15:0] b16s[2000];
        logic        s16s[2000];
        logic [31:0] t, j;
        logic [63:0] r;
        for (int k = 0; k < 2000; k++) begin
            a16s[k] = 16'($urandom); b16s[k] = 16'($urandom); s16s[k] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 65539; i++) begin
            @(negedge clk);
            t = i;
            v4  = (i < 512);   a4  = t[3:0];  b4  = t[7:4];  s4 = t[8];
            v8u = (i < 65536); a8u = t[7:0];  b8u = t[15:8];
            v8s = (i < 65536); a8s = t[7:0];  b8s = t[15:8];
            v16 = (i < 2000);
            if (i < 2000) begin a16 = a16s[i]; b16 = b16s[i]; s16 = s16s[i]; end
            #1;
            if (i >= 3) begin
                j = i - 3;
                if (j < 512) begin
                    r = ref_mul({28'd0, j[3:0]}, {28'd0, j[7:4]}, j[8], 4);
                    n_checks++;
                    if (ov4 !== 1'b1 || y4 !== r[7:0] || os4 !== j[8]) begin
                        n_fail++; $display("FAIL w4[%0d]: got v=%b y=%h s=%b expected y=%h s=%b", j, ov4, y4, os4, r[7:0], j[8]);
                    end
                end
                if (j < 65536) begin
                    r = ref_mul({24'd0, j[7:0]}, {24'd0, j[15:8]}, 1'b0, 8);
                    n_checks++;
                    if (ov8u !== 1'b1 || y8u !== r[15:0] || os8u !== 1'b0) begin
                        n_fail++; $display("FAIL w8u[%0d]: got v=%b y=%h expected %h", j, ov8u, y8u, r[15:0]);
                    end
                    r = ref_mul({24'd0, j[7:0]}, {24'd0, j[15:8]}, 1'b1, 8);
                    n_checks++;
                    if (ov8s !== 1'b1 || y8s !== r[15:0] || os8s !== 1'b1) begin
                        n_fail++; $display("FAIL w8s[%0d]: got v=%b y=%h expected %h", j, ov8s, y8s, r[15:0]);
                    end
                    if (j[15:0] == 16'hFF80) begin
                        n_checks++;
                        if (y8s !== 16'h0080) begin n_fail++; $display("FAIL w8s_80xff: got %h expected 0080", y8s); end
                    end
                end
                if (j < 2000) begin
                    r = ref_mul({16'd0, a16s[j]}, {16'd0, b16s[j]}, s16s[j], 16);
                    n_checks++;
                    if (ov16 !== 1'b1 || y16 !== r[31:0] || os16 !== s16s[j]) begin
                        n_fail++; $display("FAIL w16[%0d]: got v=%b y=%h expected %h", j, ov16, y16, r[31:0]);
                    end
                end
            end
        end
        @(negedge clk);
        v4 = 1'b0; v8u = 1'b0; v8s = 1'b0; v16 = 1'b0;
    endtask

    initial begin
        m_iv = 1'b0; m_or = 1'b1; m_a = '0; m_b = '0; m_s = 1'b0;
        sw_rdy = 1'b1; s8u_c = 1'b0; s8s_c = 1'b1;
        v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
        v8u = 1'b0; a8u = '0; b8u = '0;
        v8s = 1'b0; a8s = '0; b8s = '0;
        v16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
